// File: rtl/rb_pkg.sv
// Shared address-map helpers and load-FSM state type for the EV22 register bank.
package rb_pkg;

    typedef enum logic [0:0] {RB_IDLE, RB_WAIT} rb_state_e;

    function automatic int unsigned addr_pi_base(input int unsigned num_gpr);
        return num_gpr;
    endfunction

    function automatic int unsigned addr_po_base(input int unsigned num_gpr,
                                                 input int unsigned num_pi);
        return num_gpr + num_pi;
    endfunction

    function automatic int unsigned addr_w(input int unsigned num_gpr,
                                           input int unsigned num_pi,
                                           input int unsigned num_po);
        return num_gpr + num_pi + num_po;
    endfunction

endpackage

// File: rtl/rb_sync2.sv
// Two-flop synchroniser for one asynchronous input port, cleared by reset.
module rb_sync2 #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_q;
    logic [DATA_W-1:0] sync_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/param_register_bank.sv
// Flat-addressed GPR / PI / PO / W register bank with two read ports, one write port
// and a handshaked memory load into W.
module param_register_bank
    import rb_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_GPR = 28,
    parameter int unsigned NUM_PI  = 2,
    parameter int unsigned NUM_PO  = 2,
    parameter int unsigned BYPASS  = 0,
    parameter int unsigned SEL_W   = $clog2(NUM_GPR + NUM_PI + NUM_PO + 1)
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [SEL_W-1:0]         sel_a,
    input  logic [SEL_W-1:0]         sel_b,
    output logic [DATA_W-1:0]        rd_a,
    output logic [DATA_W-1:0]        rd_b,
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_PI*DATA_W-1:0] pi,
    output logic [NUM_PO*DATA_W-1:0] po,
    output logic [DATA_W-1:0]        w_out,
    input  logic                     ld_start,
    output logic                     mem_rd_req,
    input  logic                     mem_rd_valid,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     busy,
    output logic                     wr_err
);

    localparam int unsigned PI_BASE = addr_pi_base(NUM_GPR);
    localparam int unsigned PO_BASE = addr_po_base(NUM_GPR, NUM_PI);
    localparam int unsigned ADDR_W  = addr_w(NUM_GPR, NUM_PI, NUM_PO);

    logic [DATA_W-1:0] gpr_q   [NUM_GPR];
    logic [DATA_W-1:0] po_q    [NUM_PO];
    logic [DATA_W-1:0] pi_sync [NUM_PI];
    logic [DATA_W-1:0] w_q;
    logic              wr_err_q, wr_err_d;
    rb_state_e         state_q, state_d;

    int unsigned wr_idx;
    logic        wr_gpr, wr_po, wr_w, wr_hit;

    for (genvar g = 0; g < NUM_PI; g++) begin : g_pi_sync
        rb_sync2 #(.DATA_W(DATA_W)) u_sync (
            .clk    (clk),
            .nreset (nreset),
            .d      (pi[g*DATA_W +: DATA_W]),
            .q      (pi_sync[g])
        );
    end

    // Decode the C-bus target; W is locked while a load owns it.
    always_comb begin
        wr_idx   = 32'(wr_sel);
        wr_gpr   = wr_idx < NUM_GPR;
        wr_po    = (wr_idx >= PO_BASE) && (wr_idx < ADDR_W);
        wr_w     = wr_idx == ADDR_W;
        wr_hit   = wr_en && (wr_gpr || wr_po || (wr_w && state_q != RB_WAIT));
        wr_err_d = wr_en && !(wr_gpr || wr_po || wr_w);
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [SEL_W-1:0] sel);
        logic [DATA_W-1:0] val;
        int unsigned       idx;
        idx = 32'(sel);
        val = '0;
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            if (idx == i) val = gpr_q[i];
        end
        for (int unsigned i = 0; i < NUM_PI; i++) begin
            if (idx == PI_BASE + i) val = pi_sync[i];
        end
        for (int unsigned i = 0; i < NUM_PO; i++) begin
            if (idx == PO_BASE + i) val = po_q[i];
        end
        if (idx == ADDR_W) val = w_q;
        if (BYPASS != 0 && wr_hit && sel == wr_sel) val = wr_data;
        return val;
    endfunction

    always_comb begin
        rd_a = read_reg(sel_a);
        rd_b = read_reg(sel_b);
    end

    always_comb begin
        state_d    = state_q;
        mem_rd_req = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            RB_IDLE: begin
                if (ld_start) state_d = RB_WAIT;
            end
            RB_WAIT: begin
                mem_rd_req = 1'b1;
                busy       = 1'b1;
                if (mem_rd_valid) state_d = RB_IDLE;
            end
            default: state_d = RB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            for (int unsigned i = 0; i < NUM_PO; i++) po_q[i] <= '0;
            w_q      <= '0;
            wr_err_q <= 1'b0;
            state_q  <= RB_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                if (wr_hit && wr_idx == i) gpr_q[i] <= wr_data;
            end
            for (int unsigned i = 0; i < NUM_PO; i++) begin
                if (wr_hit && wr_idx == PO_BASE + i) po_q[i] <= wr_data;
            end
            if (state_q == RB_WAIT && mem_rd_valid) begin
                w_q <= mem_rd_data;
            end else if (wr_hit && wr_w) begin
                w_q <= wr_data;
            end
            wr_err_q <= wr_err_d;
            state_q  <= state_d;
        end
    end

    for (genvar g = 0; g < NUM_PO; g++) begin : g_po
        assign po[g*DATA_W +: DATA_W] = po_q[g];
    end

    assign w_out  = w_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Randomised bench for param_register_bank against an address-map level model;
// a BYPASS=0 and a BYPASS=1 instance share all inputs.
module tb_param_register_bank;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [5:0]  sel_a = '0, sel_b = '0, wr_sel = '0;
    logic        wr_en = 1'b0, ld_start = 1'b0, mem_rd_valid = 1'b0;
    logic [15:0] wr_data = '0, mem_rd_data = '0;
    logic [31:0] pi = '0;

    logic [15:0] rd_a0, rd_b0, w0, rd_a1, rd_b1, w1;
    logic [31:0] po0, po1;
    logic        req0, busy0, err0, req1, busy1, err1;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: the flat register map at the granularity the datapath sees it.
    logic [15:0] m_gpr [28];
    logic [15:0] m_po  [2];
    logic [15:0] m_s1  [2];
    logic [15:0] m_s2  [2];
    logic [15:0] m_w;
    bit          m_busy, m_err;

    always #5 clk = ~clk;

    param_register_bank #(.BYPASS(0)) u_dut0 (
        .clk(clk), .nreset(nreset), .sel_a(sel_a), .sel_b(sel_b), .rd_a(rd_a0), .rd_b(rd_b0),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pi(pi), .po(po0), .w_out(w0),
        .ld_start(ld_start), .mem_rd_req(req0), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .busy(busy0), .wr_err(err0)
    );

    param_register_bank #(.BYPASS(1)) u_dut1 (
        .clk(clk), .nreset(nreset), .sel_a(sel_a), .sel_b(sel_b), .rd_a(rd_a1), .rd_b(rd_b1),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pi(pi), .po(po1), .w_out(w1),
        .ld_start(ld_start), .mem_rd_req(req1), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .busy(busy1), .wr_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_wr_eff();
        int unsigned a;
        a = 32'(wr_sel);
        return wr_en && (a < 28 || (a >= 30 && a < 32) || (a == 32 && !m_busy));
    endfunction

    function automatic logic [15:0] m_read(input int unsigned a, input bit byp);
        if (byp && m_wr_eff() && a == 32'(wr_sel)) return wr_data;
        if (a < 28) return m_gpr[a];
        if (a < 30) return m_s2[a-28];
        if (a < 32) return m_po[a-30];
        if (a == 32) return m_w;
        return 16'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 28; i++) m_gpr[i] = '0;
        for (int i = 0; i < 2; i++) begin
            m_po[i] = '0; m_s1[i] = '0; m_s2[i] = '0;
        end
        m_w = '0; m_busy = 0; m_err = 0;
    endtask

    task automatic model_step();
        int unsigned a;
        bit          eff, nbusy;
        a     = 32'(wr_sel);
        eff   = m_wr_eff();
        m_err = wr_en && ((a >= 28 && a < 30) || a > 32);
        if (eff) begin
            if (a < 28) m_gpr[a] = wr_data;
            else if (a < 32) m_po[a-30] = wr_data;
            else m_w = wr_data;
        end
        if (m_busy && mem_rd_valid) m_w = mem_rd_data;
        nbusy  = m_busy ? !mem_rd_valid : ld_start;
        m_busy = nbusy;
        m_s2   = m_s1;
        for (int i = 0; i < 2; i++) m_s1[i] = pi[i*16 +: 16];
    endtask

    // Check read ports before the edge, advance the model, then check state after it.
    task automatic cycle();
        #1;
        check("rd_a_nobyp", {16'h0, rd_a0}, {16'h0, m_read(32'(sel_a), 0)});
        check("rd_b_nobyp", {16'h0, rd_b0}, {16'h0, m_read(32'(sel_b), 0)});
        check("rd_a_byp",   {16'h0, rd_a1}, {16'h0, m_read(32'(sel_a), 1)});
        check("rd_b_byp",   {16'h0, rd_b1}, {16'h0, m_read(32'(sel_b), 1)});
        model_step();
        @(posedge clk);
        #1;
        check("w_out",      {16'h0, w0}, {16'h0, m_w});
        check("w_out_byp",  {16'h0, w1}, {16'h0, m_w});
        check("po",         po0, {m_po[1], m_po[0]});
        check("busy",       {31'h0, busy0}, {31'h0, m_busy});
        check("mem_rd_req", {31'h0, req0}, {31'h0, m_busy});
        check("wr_err",     {31'h0, err0}, {31'h0, m_err});
    endtask

    task automatic quiet();
        wr_en = 0; ld_start = 0; mem_rd_valid = 0;
    endtask

    task automatic do_reset();
        quiet();
        nreset = 0;
        #1;
        model_clear();
        check("rst_busy", {31'h0, busy0}, 32'h0);
        check("rst_req",  {31'h0, req0}, 32'h0);
        check("rst_w",    {16'h0, w0}, 32'h0);
        check("rst_po",   po0, 32'h0);
        check("rst_err",  {31'h0, err0}, 32'h0);
        @(posedge clk);
        #1;
        nreset = 1;
    endtask

    int busy_cnt;

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Write then read a GPR; neighbour stays 0.
        wr_en = 1; wr_sel = 5; wr_data = 16'h1234; sel_a = 5; sel_b = 6;
        cycle();
        quiet();
        #1;
        check("t1_gpr5", {16'h0, rd_a0}, 32'h1234);
        check("t1_gpr6", {16'h0, rd_b0}, 32'h0);

        // Read-during-write with and without bypass.
        wr_en = 1; wr_sel = 3; wr_data = 16'hBEEF; sel_b = 3;
        #1;
        check("t2_old",   {16'h0, rd_b0}, 32'h0);
        check("t2_byp",   {16'h0, rd_b1}, 32'hBEEF);
        cycle();
        quiet();
        #1;
        check("t2_new",   {16'h0, rd_b0}, 32'hBEEF);

        // Illegal writes and PI synchronisation.
        pi = 32'h0000_A5A5; sel_a = 28;
        wr_en = 1; wr_sel = 28; wr_data = 16'hDEAD;
        cycle();
        check("t3_err_pi", {31'h0, err0}, 32'h1);
        wr_sel = 40;
        cycle();
        check("t3_err_hi", {31'h0, err0}, 32'h1);
        quiet();
        #1;
        check("t3_pi_rd", {16'h0, rd_a0}, 32'hA5A5);
        cycle();
        check("t3_err_clr", {31'h0, err0}, 32'h0);

        // Load with a dropped C-bus write to W in the wait window.
        busy_cnt = 0;
        ld_start = 1;
        cycle();
        ld_start = 0;
        busy_cnt += int'(busy0);
        wr_en = 1; wr_sel = 32; wr_data = 16'h1111;
        cycle();
        busy_cnt += int'(busy0);
        quiet();
        cycle();
        busy_cnt += int'(busy0);
        mem_rd_valid = 1; mem_rd_data = 16'h7777;
        cycle();
        busy_cnt += int'(busy0);
        quiet();
        check("t4_w",    {16'h0, w0}, 32'h7777);
        check("t4_busy", busy_cnt, 3);

        // Reset in the middle of a load, then a late valid.
        ld_start = 1;
        cycle();
        quiet();
        cycle();
        do_reset();
        mem_rd_valid = 1; mem_rd_data = 16'h5555;
        cycle();
        quiet();
        check("t5_w",   {16'h0, w0}, 32'h0);
        check("t5_req", {31'h0, req0}, 32'h0);

        // Output ports.
        wr_en = 1; wr_sel = 30; wr_data = 16'h00FF;
        cycle();
        wr_sel = 31; wr_data = 16'hFF00;
        cycle();
        quiet();
        check("t6_po", po0, 32'hFF00_00FF);
        do_reset();

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            sel_a        = 6'($urandom_range(0, 40));
            sel_b        = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 33));
            wr_en        = $urandom_range(0, 2) != 0;
            wr_sel       = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 33));
            wr_data      = 16'($urandom);
            ld_start     = $urandom_range(0, 5) == 0;
            mem_rd_valid = $urandom_range(0, 3) == 0;
            mem_rd_data  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pi = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
